// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_W data bits LSB first, optional parity, one or two stop bits.
// Optional feature: define UART_TX_BREAK_EN to add the break_req input for sending line breaks.
module uart_tx_framer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        parity_type,
  input  logic              stop2,
  input  logic              valid,
`ifdef UART_TX_BREAK_EN
  input  logic              break_req,
`endif
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  if ((DATA_W < 5) || (DATA_W > 9)) begin : g_bad_data_w
    $fatal(1, "uart_tx_framer: DATA_W=%0d is outside 5..9", DATA_W);
  end

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  typedef enum logic [3:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_BREAK_EN
    ,
    BRK_HOLD,
    BRK_ALIGN,
    BRK_MARK
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // All outputs come straight from flops, so reset forces the idle line level immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      // Ticks are ignored here; the frame aligns to the first tick seen in WAIT.
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_d = BRK_HOLD;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end else
`endif
        if (valid && ready_q) begin
          state_d   = WAIT;
          shreg_d   = data_in;
          par_en_d  = (parity_type == 2'b01) || (parity_type == 2'b10);
          par_bit_d = (^data_in) ^ (parity_type == 2'b01);
          stop2_d   = stop2;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
        end
      end
      WAIT: begin
        if (baud_tick) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == stop2_q) begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      // After a break the line idles high for one complete tick interval before new frames.
      BRK_HOLD: begin
        if (!break_req) begin
          state_d = BRK_ALIGN;
          tx_d    = 1'b1;
        end
      end
      BRK_ALIGN: begin
        if (baud_tick) begin
          state_d = BRK_MARK;
        end
      end
      BRK_MARK: begin
        if (baud_tick) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data bits per frame (legal 5..9).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is clocked on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port baud_tick, input, 1, a one-clk pulse marking each bit-period boundary.
REQ-005 The block SHALL have port data_in, input, DATA_W, the frame payload.
REQ-006 The block SHALL have port parity_type, input, 2: 00 none, 01 odd, 10 even, 11 none.
REQ-007 The block SHALL have port stop2, input, 1: 0 selects one stop bit, 1 selects two.
REQ-008 The block SHALL have port valid, input, 1, a request to send data_in.
REQ-009 The block SHALL have port ready, output, 1, high when a request can be accepted.
REQ-010 The block SHALL have port tx, output, 1, the serial line, idle high.
REQ-011 The block SHALL have port busy, output, 1, high from acceptance until the frame ends.
REQ-012 The block SHALL have port done, output, 1, a one-clk pulse at frame end.

Function
REQ-013 The FSM SHALL have the states IDLE, WAIT, START, DATA, PARITY and STOP.
REQ-014 Acceptance SHALL occur on any clk edge where valid and ready are both high; ready SHALL be high only in IDLE.
REQ-015 On acceptance, data_in, parity_type and stop2 SHALL be latched; later changes to these inputs SHALL not affect the frame in flight.
REQ-016 IDLE SHALL go to WAIT on acceptance; WAIT SHALL go to START on the next baud_tick.
REQ-017 Bit timing SHALL work as follows:
- tx=0 in START;
- each bit (start, data, parity, stop) lasts from one baud_tick to the next;
- every bit lasts exactly one tick interval.
REQ-018 Data SHALL be sent LSB first; a bit counter SHALL advance on baud_tick in DATA; DATA SHALL exit after DATA_W bits.
REQ-019 PARITY SHALL be entered only when the latched parity_type is 01 or 10; otherwise DATA SHALL go directly to STOP.
REQ-020 The parity bit SHALL be the XOR of all DATA_W latched bits for even parity, and its inverse for odd parity.
REQ-021 STOP SHALL drive tx=1 for one tick interval, or two when the latched stop2=1.
REQ-022 On the baud_tick ending the last stop bit, the FSM SHALL return to IDLE, and done SHALL pulse high in the following cycle with ready=1 and busy=0.
REQ-023 A valid held high across frame end SHALL be accepted in the first IDLE cycle; with a continuous baud_tick stream, frames SHALL be back-to-back with no idle bit beyond the WAIT alignment.
REQ-024 A baud_tick arriving in the same cycle as acceptance SHALL be ignored; WAIT SHALL require a later tick.
REQ-025 A baud_tick in IDLE SHALL have no effect.
REQ-026 tx, busy, ready and done SHALL be registered outputs, with no combinational path from inputs.
REQ-027 An illegal DATA_W SHALL be flagged at elaboration with a fatal assertion.

Reset
REQ-028 While rst_n=0, the block SHALL be in IDLE with tx=1, ready=1, busy=0, done=0, and counters and latches cleared.
REQ-029 A reset asserted mid-frame SHALL abort the frame immediately, driving tx=1 asynchronously; no done SHALL be produced.
REQ-030 After rst_n deasserts, the first acceptance SHALL be possible on the next clk edge.

Configuration
REQ-031 When macro UART_TX_BREAK_EN is defined, a 1-bit input break_req SHALL exist with the following behaviour:
- sampled only in IDLE;
- when high, ready=0, busy=1 and tx=0 for as long as it stays high;
- after it falls, tx=1 for one full tick interval before ready returns.
REQ-032 When UART_TX_BREAK_EN is undefined, port break_req and its logic SHALL be absent, and behaviour SHALL be exactly as REQ-013..REQ-027.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- DATA_W=8, data 0xA5, parity 10, stop2=0, tick every 16 clk -> tx 0,1,0,1,0,0,1,0,1,0(parity),1; done 16 clk after the last tick of the parity bit.
- Same data, parity 01 -> parity bit=1; parity 00 and 11 -> 10-bit frame with no parity bit.
- DATA_W=5, data 0x1F, parity 10, stop2=1 -> tx 0,1,1,1,1,1,1(parity),1,1; busy spans 9 tick intervals.
- valid held high, two words 0x00 then 0xFF, continuous ticks -> second start bit begins one tick after the first frame's stop bit ends; data_in change during frame 1 ignored.
- rst_n pulled low during DATA bit 3 -> tx=1 the same cycle, no done, ready=1; a fresh frame after release is correct.
- With UART_TX_BREAK_EN: break_req high for 40 ticks -> tx low for 40 ticks, then high for 1 tick, then ready=1; valid during break not accepted.
